// File: rtl/sop_result_reader_pkg.sv
// Shared definitions for the sum-of-products result path: operand width default,
// result width rule and the reader's per-cycle control bundle.
package sop_result_reader_pkg;

    localparam int SOP_SIZE = 4;

    // Result of a SIZE x SIZE sum of products plus carry headroom.
    function automatic int sop_result_w(input int size);
        return 2 * size + 2;
    endfunction

    typedef struct packed {
        logic push;
        logic pop;
        logic drop;
    } rd_ctl_t;

endpackage

// File: rtl/sop_rd_fifo.sv
// Result buffer: DEPTH-entry circular store with read/write pointers and occupancy.
// Storage is not reset; only pointers and occupancy are.
module sop_rd_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wr_data,
    output logic [W-1:0]  rd_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH == 2**AW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);

endmodule

// File: rtl/sop_result_reader.sv
// Receiving end of the sum-of-products datapath: buffers results without
// backpressure, hands them out over valid/ready, and keeps overflow/peak statistics.
module sop_result_reader
    import sop_result_reader_pkg::*;
#(
    parameter int  SIZE  = SOP_SIZE,
    parameter int  DEPTH = 4,
    parameter int  AW    = 2,
    localparam int W     = sop_result_w(SIZE)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [W-1:0]  SOP_IN,
    input  logic          IN_VALID,
    output logic [W-1:0]  DOUT,
    output logic          DOUT_VALID,
    input  logic          DOUT_READY,
    output logic [AW:0]   COUNT,
    output logic          FULL,
    output logic          OVERFLOW,
    input  logic          CLR_STAT,
    output logic [W-1:0]  PEAK
);

    function automatic logic [W-1:0] umax(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    rd_ctl_t      ctl;
    logic [W-1:0] fifo_rd_data;
    logic         fifo_full;
    logic         fifo_empty;

    // A pop frees a slot in the same cycle, so a full buffer can still accept.
    always_comb begin
        ctl      = '0;
        ctl.pop  = !fifo_empty && DOUT_READY;
        ctl.push = IN_VALID && (!fifo_full || ctl.pop);
        ctl.drop = IN_VALID && fifo_full && !ctl.pop;
    end

    sop_rd_fifo #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RST),
        .push    (ctl.push),
        .pop     (ctl.pop),
        .wr_data (SOP_IN),
        .rd_data (fifo_rd_data),
        .count   (COUNT),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A drop in the same cycle as a clear leaves OVERFLOW set.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            OVERFLOW <= 1'b0;
        end else if (ctl.drop) begin
            OVERFLOW <= 1'b1;
        end else if (CLR_STAT) begin
            OVERFLOW <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            PEAK <= '0;
        end else if (ctl.push) begin
            PEAK <= CLR_STAT ? SOP_IN : umax(PEAK, SOP_IN);
        end else if (CLR_STAT) begin
            PEAK <= '0;
        end
    end

    // Unwritten storage is never exposed: DOUT reads zero while empty.
    assign DOUT       = fifo_empty ? '0 : fifo_rd_data;
    assign DOUT_VALID = !fifo_empty;
    assign FULL       = fifo_full;

endmodule

// File: tb/tb_sop_result_reader.sv
// Bench for sop_result_reader: directed scenarios plus randomized traffic against
// a queue-based reference model of the buffer and its statistics.
module tb_sop_result_reader;

    localparam int SIZE  = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int W     = 2 * SIZE + 2;

    logic          CLK = 1'b0;
    logic          RST;
    logic [W-1:0]  SOP_IN;
    logic          IN_VALID;
    logic [W-1:0]  DOUT;
    logic          DOUT_VALID;
    logic          DOUT_READY;
    logic [AW:0]   COUNT;
    logic          FULL;
    logic          OVERFLOW;
    logic          CLR_STAT;
    logic [W-1:0]  PEAK;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] mq[$];
    logic         m_ovf;
    logic [W-1:0] m_peak;

    always #5 CLK = ~CLK;

    sop_result_reader #(
        .SIZE  (SIZE),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .SOP_IN     (SOP_IN),
        .IN_VALID   (IN_VALID),
        .DOUT       (DOUT),
        .DOUT_VALID (DOUT_VALID),
        .DOUT_READY (DOUT_READY),
        .COUNT      (COUNT),
        .FULL       (FULL),
        .OVERFLOW   (OVERFLOW),
        .CLR_STAT   (CLR_STAT),
        .PEAK       (PEAK)
    );

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_peak = '0;
    endtask

    // Drive one cycle of inputs, advance the reference model across the edge,
    // and return 1 time unit after the edge.
    task automatic step(input logic iv, input logic [W-1:0] d, input logic rdy, input logic clr);
        bit m_pop;
        bit m_full;
        bit m_push;
        bit m_drop;
        IN_VALID   = iv;
        SOP_IN     = d;
        DOUT_READY = rdy;
        CLR_STAT   = clr;
        m_pop  = (mq.size() > 0) && rdy;
        m_full = (mq.size() == DEPTH);
        m_push = iv && (!m_full || m_pop);
        m_drop = iv && m_full && !m_pop;
        @(posedge CLK);
        if (m_pop) void'(mq.pop_front());
        if (m_push) mq.push_back(d);
        if (m_drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (m_push) m_peak = (clr || d > m_peak) ? d : m_peak;
        else if (clr) m_peak = '0;
        #1;
    endtask

    task automatic set_idle();
        IN_VALID   = 1'b0;
        SOP_IN     = '0;
        DOUT_READY = 1'b0;
        CLR_STAT   = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        RST = 1'b0;
        model_reset();
        #12;
        vectors++; if (DOUT !== '0) begin miscompares++; $display("FAIL reset_dout got %0d want 0", DOUT); end
        vectors++; if (DOUT_VALID !== 1'b0) begin miscompares++; $display("FAIL reset_dout_valid got %b want 0", DOUT_VALID); end
        vectors++; if (COUNT !== '0) begin miscompares++; $display("FAIL reset_count got %0d want 0", COUNT); end
        vectors++; if (PEAK !== '0) begin miscompares++; $display("FAIL reset_peak got %0d want 0", PEAK); end
        vectors++; if (OVERFLOW !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b want 0", OVERFLOW); end
        @(negedge CLK);
        RST = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);
        vectors++; if (DOUT_VALID !== 1'b0 || COUNT !== '0) begin miscompares++; $display("FAIL idle_state got valid=%b count=%0d want 0/0", DOUT_VALID, COUNT); end
        step(1'b1, 10'd7, 1'b0, 1'b0);
        step(1'b1, 10'd8, 1'b0, 1'b0);
        step(1'b1, 10'd9, 1'b0, 1'b0);
        vectors++; if (COUNT !== 3'd3) begin miscompares++; $display("FAIL preburst_count got %0d want 3", COUNT); end
        vectors++; if (PEAK !== 10'd9) begin miscompares++; $display("FAIL preburst_peak got %0d want 9", PEAK); end
        set_idle();
        #2;
        RST = 1'b0;
        #1;
        vectors++; if (COUNT !== '0) begin miscompares++; $display("FAIL async_count got %0d want 0", COUNT); end
        vectors++; if (DOUT_VALID !== 1'b0 || DOUT !== '0) begin miscompares++; $display("FAIL async_dout got valid=%b dout=%0d want 0/0", DOUT_VALID, DOUT); end
        vectors++; if (PEAK !== '0 || FULL !== 1'b0) begin miscompares++; $display("FAIL async_stats got peak=%0d full=%b want 0/0", PEAK, FULL); end
        model_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_basic();
        logic [W-1:0] exp_seq [3];
        exp_seq = '{10'd5, 10'd300, 10'd17};
        for (int i = 0; i < 3; i++) step(1'b1, exp_seq[i], 1'b0, 1'b0);
        vectors++; if (COUNT !== 3'd3) begin miscompares++; $display("FAIL basic_count got %0d want 3", COUNT); end
        for (int i = 0; i < 3; i++) begin
            vectors++; if (DOUT !== exp_seq[i] || DOUT_VALID !== 1'b1) begin miscompares++; $display("FAIL basic_dout[%0d] got %0d valid=%b want %0d valid=1", i, DOUT, DOUT_VALID, exp_seq[i]); end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        vectors++; if (DOUT_VALID !== 1'b0 || DOUT !== '0) begin miscompares++; $display("FAIL basic_empty got valid=%b dout=%0d want 0/0", DOUT_VALID, DOUT); end
        vectors++; if (PEAK !== 10'd300) begin miscompares++; $display("FAIL basic_peak got %0d want 300", PEAK); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, W'(i), 1'b0, 1'b0);
            if (i == 4) begin
                vectors++; if (FULL !== 1'b1 || OVERFLOW !== 1'b0) begin miscompares++; $display("FAIL ovf_full4 got full=%b ovf=%b want 1/0", FULL, OVERFLOW); end
            end
        end
        vectors++; if (OVERFLOW !== 1'b1 || COUNT !== 3'd4) begin miscompares++; $display("FAIL ovf_set got ovf=%b count=%0d want 1/4", OVERFLOW, COUNT); end
        for (int i = 1; i <= 4; i++) begin
            vectors++; if (DOUT !== W'(i)) begin miscompares++; $display("FAIL ovf_drain[%0d] got %0d want %0d", i, DOUT, i); end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        vectors++; if (DOUT_VALID !== 1'b0 || OVERFLOW !== 1'b1) begin miscompares++; $display("FAIL ovf_after got valid=%b ovf=%b want 0/1", DOUT_VALID, OVERFLOW); end
    endtask

    task automatic test_full_pushpop();
        logic [W-1:0] exp_seq [12];
        exp_seq = '{10'd20, 10'd21, 10'd22, 10'd23, 10'd10, 10'd11, 10'd12, 10'd13, 10'd14, 10'd15, 10'd16, 10'd17};
        step(1'b0, '0, 1'b0, 1'b1);
        vectors++; if (OVERFLOW !== 1'b0) begin miscompares++; $display("FAIL clr_ovf got %b want 0", OVERFLOW); end
        for (int i = 0; i < 4; i++) step(1'b1, exp_seq[i], 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            vectors++; if (DOUT !== exp_seq[k]) begin miscompares++; $display("FAIL wrap_dout[%0d] got %0d want %0d", k, DOUT, exp_seq[k]); end
            step(1'b1, W'(10 + k), 1'b1, 1'b0);
            vectors++; if (COUNT !== 3'd4 || OVERFLOW !== 1'b0) begin miscompares++; $display("FAIL wrap_count[%0d] got count=%0d ovf=%b want 4/0", k, COUNT, OVERFLOW); end
        end
        for (int j = 0; j < 4; j++) begin
            vectors++; if (DOUT !== exp_seq[8 + j]) begin miscompares++; $display("FAIL wrap_drain[%0d] got %0d want %0d", j, DOUT, exp_seq[8 + j]); end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        vectors++; if (COUNT !== '0) begin miscompares++; $display("FAIL wrap_empty got %0d want 0", COUNT); end
    endtask

    task automatic test_empty_pushpop();
        vectors++; if (DOUT_VALID !== 1'b0) begin miscompares++; $display("FAIL ept_pre got valid=%b want 0", DOUT_VALID); end
        step(1'b1, 10'd1023, 1'b1, 1'b0);
        vectors++; if (COUNT !== 3'd1) begin miscompares++; $display("FAIL ept_count got %0d want 1", COUNT); end
        vectors++; if (DOUT !== 10'd1023 || DOUT_VALID !== 1'b1) begin miscompares++; $display("FAIL ept_dout got %0d valid=%b want 1023 valid=1", DOUT, DOUT_VALID); end
        vectors++; if (PEAK !== 10'd1023) begin miscompares++; $display("FAIL ept_peak got %0d want 1023", PEAK); end
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_clr_stat();
        logic [W-1:0] exp_seq [4];
        exp_seq = '{10'd31, 10'd32, 10'd33, 10'd9};
        for (int i = 0; i < 4; i++) step(1'b1, W'(30 + i), 1'b0, 1'b0);
        step(1'b1, 10'd40, 1'b0, 1'b0);
        vectors++; if (OVERFLOW !== 1'b1) begin miscompares++; $display("FAIL clr_drop got %b want 1", OVERFLOW); end
        step(1'b1, 10'd41, 1'b0, 1'b1);
        vectors++; if (OVERFLOW !== 1'b1 || COUNT !== 3'd4) begin miscompares++; $display("FAIL clr_setwins got ovf=%b count=%0d want 1/4", OVERFLOW, COUNT); end
        step(1'b0, '0, 1'b1, 1'b0);
        vectors++; if (COUNT !== 3'd3) begin miscompares++; $display("FAIL clr_pop got %0d want 3", COUNT); end
        step(1'b1, 10'd9, 1'b0, 1'b1);
        vectors++; if (OVERFLOW !== 1'b0) begin miscompares++; $display("FAIL clr_ovf0 got %b want 0", OVERFLOW); end
        vectors++; if (PEAK !== 10'd9) begin miscompares++; $display("FAIL clr_peak got %0d want 9", PEAK); end
        for (int j = 0; j < 4; j++) begin
            vectors++; if (DOUT !== exp_seq[j]) begin miscompares++; $display("FAIL clr_drain[%0d] got %0d want %0d", j, DOUT, exp_seq[j]); end
            step(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_random();
        logic         iv;
        logic         rdy;
        logic         clr;
        logic [W-1:0] d;
        logic [W-1:0] exp_dout;
        for (int i = 0; i < 400; i++) begin
            iv  = ($urandom_range(0, 3) != 0);
            d   = W'($urandom_range(0, 1023));
            rdy = ($urandom_range(0, 99) < ((i < 200) ? 30 : 70));
            clr = ($urandom_range(0, 15) == 0);
            step(iv, d, rdy, clr);
            exp_dout = (mq.size() > 0) ? mq[0] : '0;
            vectors++; if (DOUT !== exp_dout || DOUT_VALID !== (mq.size() > 0)) begin miscompares++; $display("FAIL rnd_dout[%0d] got %0d valid=%b want %0d valid=%b", i, DOUT, DOUT_VALID, exp_dout, mq.size() > 0); end
            vectors++; if (COUNT !== (AW + 1)'(mq.size()) || FULL !== (mq.size() == DEPTH)) begin miscompares++; $display("FAIL rnd_count[%0d] got %0d full=%b want %0d", i, COUNT, FULL, mq.size()); end
            vectors++; if (OVERFLOW !== m_ovf || PEAK !== m_peak) begin miscompares++; $display("FAIL rnd_stats[%0d] got ovf=%b peak=%0d want ovf=%b peak=%0d", i, OVERFLOW, PEAK, m_ovf, m_peak); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_pushpop();
        test_empty_pushpop();
        test_clr_stat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sop_result_reader.md
Name: sop_result_reader

Overview:
- Receiving end of the sum-of-products datapath output.
- Accepts one (2*SIZE+2)-bit unsigned result per cycle when IN_VALID is high. The producer has no backpressure.
- Buffers results in a DEPTH-entry FIFO and presents them to a downstream consumer over a valid/ready handshake.
- Tracks dropped results (sticky overflow) and the peak result accepted, so a bench or host can drain filter output at its own rate.

Parameters:
- SIZE, 4, operand width of the sum-of-products stage; result width W = 2*SIZE+2.
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.
- AW, 2, pointer width = log2(DEPTH).

Ports:
- CLK  input  1  single clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- SOP_IN  input  W  result word from the sum-of-products stage.
- IN_VALID  input  1  SOP_IN qualifier; no ready is returned to the producer.
- DOUT  output  W  head-of-FIFO word.
- DOUT_VALID  output  1  FIFO non-empty.
- DOUT_READY  input  1  consumer accepts DOUT this cycle.
- COUNT  output  AW+1  occupancy, 0..DEPTH.
- FULL  output  1  COUNT == DEPTH.
- OVERFLOW  output  1  sticky: a valid result was dropped.
- CLR_STAT  input  1  synchronous clear of OVERFLOW and PEAK.
- PEAK  output  W  largest SOP_IN accepted since reset or CLR_STAT.

Behaviour:
- Reset (RST low, asynchronous, any time, including mid-operation):
  - Pointers, COUNT, OVERFLOW and PEAK go to 0.
  - DOUT_VALID=0, FULL=0, DOUT=0.
  - Storage contents need not be cleared. DOUT is forced to 0 whenever empty.
- Signal definitions:
  - push = IN_VALID && (!FULL || pop).
  - pop = DOUT_VALID && DOUT_READY.
- Push writes SOP_IN at wr_ptr and increments wr_ptr modulo DEPTH (wraps naturally).
- Pop increments rd_ptr modulo DEPTH.
- COUNT: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency:
  - A word pushed at edge N is visible on DOUT with DOUT_VALID=1 from edge N onward. First-word latency is 1 cycle.
  - DOUT is combinational from the registered storage and rd_ptr. No bubble between consecutive pops.
- Full with simultaneous pop: push is allowed, COUNT stays DEPTH, no overflow.
- Empty with IN_VALID and DOUT_READY: pop is ignored and the push completes. No fall-through in the same cycle.
- Overflow:
  - Condition: IN_VALID && FULL && !pop. The word is dropped, storage is unchanged, OVERFLOW=1 at the next edge.
  - OVERFLOW holds until CLR_STAT or reset.
  - CLR_STAT and a new drop in the same cycle: OVERFLOW=1 (set wins).
- PEAK (unsigned compare):
  - On push, PEAK <= max(PEAK, SOP_IN).
  - CLR_STAT and push in the same cycle: PEAK <= SOP_IN.
  - Dropped words never update PEAK.
- DOUT_READY while empty has no effect.
- Reader state is fully synchronous to CLK. There is no other state machine; control is pointer/counter based.

Decomposition:
- Shared include file:
  - SIZE default.
  - Result-width expression 2*SIZE+2, shared with the datapath top level.
- One sub-module, sop_rd_fifo:
  - Contains the storage array, pointers and COUNT/FULL/empty.
  - The parent adds overflow and peak logic and the DOUT zero-gating.

Test Plan (SIZE=4, W=10, DEPTH=4):
- Reset then idle → DOUT=0, DOUT_VALID=0, COUNT=0, PEAK=0. Assert RST low mid-burst with COUNT=3 → all outputs 0 immediately, before the next edge.
- Push 10'd5, 10'd300, 10'd17 with DOUT_READY=0 → COUNT=3. Then hold DOUT_READY=1 → DOUT reads 5, 300, 17 on consecutive cycles, then DOUT_VALID=0. PEAK=300.
- Push 6 words 1..6 with DOUT_READY=0 → FULL after the 4th push. Words 5 and 6 are dropped, OVERFLOW=1. Drain yields 1,2,3,4.
- While FULL, IN_VALID=1 and DOUT_READY=1 for 8 cycles with data 10..17 → COUNT stays 4, OVERFLOW stays 0. Output sequence continues in order, exercising pointer wrap-around.
- Empty FIFO, IN_VALID=1 (data 1023) and DOUT_READY=1 in the same cycle → COUNT=1, DOUT=1023 on the next cycle, PEAK=1023.
- OVERFLOW=1, assert CLR_STAT in the same cycle as another drop → OVERFLOW remains 1. CLR_STAT alone with push of 9 → OVERFLOW=0, PEAK=9.
